// File: rtl/gru_seq_cell.sv
// rtl/gru_seq_cell.sv - sequential fixed-point GRU cell with internal hidden state
//
// Purpose: one GRU time step per accepted sample, hidden state kept between steps.
//          Pipeline IDLE -> GATES -> CAND -> UPD -> OUT, signed saturating arithmetic.
// Ports:
//   clk, rst              clock (rising edge), asynchronous active-high reset
//   x_valid/x_ready/x_in  input sample handshake and data
//   seq_start             first step of a sequence (h_prev forced to 0)
//   Wz..Uh, bz..bh        weights and biases, latched on accept
//   y_valid/y_ready/h_out new hidden state handshake and data
module gru_seq_cell #(
    parameter int DATA_WIDTH  = 8,
    parameter int FRACT_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  x_valid,
    output logic                  x_ready,
    input  logic [DATA_WIDTH-1:0] x_in,
    input  logic                  seq_start,
    input  logic [DATA_WIDTH-1:0] Wz,
    input  logic [DATA_WIDTH-1:0] Wr,
    input  logic [DATA_WIDTH-1:0] Wh,
    input  logic [DATA_WIDTH-1:0] Uz,
    input  logic [DATA_WIDTH-1:0] Ur,
    input  logic [DATA_WIDTH-1:0] Uh,
    input  logic [DATA_WIDTH-1:0] bz,
    input  logic [DATA_WIDTH-1:0] br,
    input  logic [DATA_WIDTH-1:0] bh,
    output logic                  y_valid,
    input  logic                  y_ready,
    output logic [DATA_WIDTH-1:0] h_out
);

    localparam int W  = DATA_WIDTH;
    localparam int F  = FRACT_WIDTH;
    localparam int PW = 2 * W;
    // Two guard bits: a sum of three PW-bit terms cannot overflow SW.
    localparam int SW = 2 * W + 2;

    localparam logic signed [SW-1:0] SAT_HI  = SW'((1 << (W - 1)) - 1);
    localparam logic signed [SW-1:0] SAT_LO  = ~SAT_HI;
    localparam logic signed [W-1:0]  ONE_W   = W'(1 << F);
    localparam logic signed [W-1:0]  NONE_W  = -ONE_W;
    localparam logic signed [W:0]    ONE_X   = (W + 1)'(1 << F);
    localparam logic signed [W:0]    HALF_X  = (W + 1)'(1 << (F - 1));
    localparam logic signed [W:0]    ZERO_X  = '0;

    typedef logic signed [W-1:0] word_t;

    typedef enum logic [2:0] {
        IDLE,
        GATES,
        CAND,
        UPD,
        OUT
    } state_t;

    typedef struct packed {
        word_t wz;
        word_t wr;
        word_t wh;
        word_t uz;
        word_t ur;
        word_t uh;
        word_t bz;
        word_t br;
        word_t bh;
    } prm_t;

    // Full-precision product, floor-shifted back to the fixed-point grid.
    function automatic logic signed [PW-1:0] mul(input word_t a, input word_t b);
        logic signed [PW-1:0] p;
        p   = a * b;
        mul = p >>> F;
    endfunction

    function automatic word_t sat(input logic signed [SW-1:0] v);
        if (v > SAT_HI) begin
            sat = SAT_HI[W-1:0];
        end else if (v < SAT_LO) begin
            sat = SAT_LO[W-1:0];
        end else begin
            sat = v[W-1:0];
        end
    endfunction

    // Hard sigmoid; one extra bit so the +ONE/2 offset cannot overflow.
    function automatic word_t sig(input word_t v);
        logic signed [W:0] ve;
        logic signed [W:0] t;
        ve = {v[W-1], v};
        t  = (ve >>> 2) + HALF_X;
        if (t < ZERO_X) begin
            t = ZERO_X;
        end else if (t > ONE_X) begin
            t = ONE_X;
        end
        sig = t[W-1:0];
    endfunction

    function automatic word_t tnh(input word_t v);
        if (v > ONE_W) begin
            tnh = ONE_W;
        end else if (v < NONE_W) begin
            tnh = NONE_W;
        end else begin
            tnh = v;
        end
    endfunction

    state_t state_q, state_d;
    prm_t   prm_q, prm_d;
    word_t  x_q, x_d;
    word_t  hp_q, hp_d;
    word_t  h_q, h_d;
    word_t  z_q, z_d;
    word_t  r_q, r_d;
    word_t  ht_q, ht_d;
    word_t  h_out_q, h_out_d;
    logic   y_valid_q, y_valid_d;

    word_t z_new, r_new, rh, ht_new, diff, hn_new;

    assign z_new  = sig(sat(SW'(prm_q.bz) + SW'(mul(prm_q.wz, x_q)) + SW'(mul(prm_q.uz, hp_q))));
    assign r_new  = sig(sat(SW'(prm_q.br) + SW'(mul(prm_q.wr, x_q)) + SW'(mul(prm_q.ur, hp_q))));
    assign rh     = sat(SW'(mul(r_q, hp_q)));
    assign ht_new = tnh(sat(SW'(prm_q.bh) + SW'(mul(prm_q.wh, x_q)) + SW'(mul(prm_q.uh, rh))));
    assign diff   = sat(SW'(ht_q) - SW'(hp_q));
    assign hn_new = sat(SW'(hp_q) + SW'(mul(z_q, diff)));

    assign x_ready = (state_q == IDLE);
    assign y_valid = y_valid_q;
    assign h_out   = h_out_q;

    always_comb begin
        state_d   = state_q;
        prm_d     = prm_q;
        x_d       = x_q;
        hp_d      = hp_q;
        h_d       = h_q;
        z_d       = z_q;
        r_d       = r_q;
        ht_d      = ht_q;
        h_out_d   = h_out_q;
        y_valid_d = y_valid_q;
        case (state_q)
            IDLE: begin
                if (x_valid && x_ready) begin
                    x_d      = x_in;
                    prm_d.wz = Wz;
                    prm_d.wr = Wr;
                    prm_d.wh = Wh;
                    prm_d.uz = Uz;
                    prm_d.ur = Ur;
                    prm_d.uh = Uh;
                    prm_d.bz = bz;
                    prm_d.br = br;
                    prm_d.bh = bh;
                    hp_d     = seq_start ? '0 : h_q;
                    state_d  = GATES;
                end
            end
            GATES: begin
                z_d     = z_new;
                r_d     = r_new;
                state_d = CAND;
            end
            CAND: begin
                ht_d    = ht_new;
                state_d = UPD;
            end
            UPD: begin
                h_d       = hn_new;
                h_out_d   = hn_new;
                y_valid_d = 1'b1;
                state_d   = OUT;
            end
            OUT: begin
                // No turnaround: x_ready only returns once back in IDLE.
                if (y_valid_q && y_ready) begin
                    y_valid_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            prm_q     <= '0;
            x_q       <= '0;
            hp_q      <= '0;
            h_q       <= '0;
            z_q       <= '0;
            r_q       <= '0;
            ht_q      <= '0;
            h_out_q   <= '0;
            y_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            prm_q     <= prm_d;
            x_q       <= x_d;
            hp_q      <= hp_d;
            h_q       <= h_d;
            z_q       <= z_d;
            r_q       <= r_d;
            ht_q      <= ht_d;
            h_out_q   <= h_out_d;
            y_valid_q <= y_valid_d;
        end
    end

endmodule

// File: tb/tb_gru_seq_cell.sv
// tb/tb_gru_seq_cell.sv - directed vector bench for gru_seq_cell
module tb_gru_seq_cell;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       x_valid = 1'b0;
    logic       x_ready;
    logic [7:0] x_in = '0;
    logic       seq_start = 1'b0;
    logic [7:0] Wz = '0, Wr = '0, Wh = '0, Uz = '0, Ur = '0, Uh = '0;
    logic [7:0] bz = '0, br = '0, bh = '0;
    logic       y_valid;
    logic       y_ready = 1'b1;
    logic [7:0] h_out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    gru_seq_cell #(.DATA_WIDTH(8), .FRACT_WIDTH(5)) dut (
        .clk(clk), .rst(rst),
        .x_valid(x_valid), .x_ready(x_ready), .x_in(x_in), .seq_start(seq_start),
        .Wz(Wz), .Wr(Wr), .Wh(Wh), .Uz(Uz), .Ur(Ur), .Uh(Uh),
        .bz(bz), .br(br), .bh(bh),
        .y_valid(y_valid), .y_ready(y_ready), .h_out(h_out)
    );

    typedef struct {
        logic       ss;
        logic [7:0] x, wz, wr, wh, uz, ur, uh, bz, br, bh;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic accept(input vec_t v);
        @(negedge clk);
        seq_start = v.ss; x_in = v.x;
        Wz = v.wz; Wr = v.wr; Wh = v.wh; Uz = v.uz; Ur = v.ur; Uh = v.uh;
        bz = v.bz; br = v.br; bh = v.bh;
        x_valid = 1'b1;
        chk("x_ready_before_accept", x_ready, 1);
        @(posedge clk);
        #1;
        x_valid = 1'b0;
        // Inputs wander after the accept edge; the step must not see this.
        seq_start = 1'($urandom); x_in = 8'($urandom);
        Wz = 8'($urandom); Wr = 8'($urandom); Wh = 8'($urandom);
        Uz = 8'($urandom); Ur = 8'($urandom); Uh = 8'($urandom);
        bz = 8'($urandom); br = 8'($urandom); bh = 8'($urandom);
    endtask

    // Called just after the accept edge; samples after T+1, T+2, T+3.
    task automatic wait_out(input string name, input logic [7:0] exp);
        logic early;
        early = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
            if (y_valid) early = 1'b1;
        end
        @(posedge clk);
        #1;
        chk({name, "_latency"}, {early, y_valid}, 2'b01);
        chk({name, "_h_out"}, h_out, exp);
    endtask

    task automatic handshake(input string name);
        @(negedge clk);
        y_ready = 1'b1;
        @(posedge clk);
        #1;
        chk({name, "_hs_done"}, {y_valid, x_ready}, 2'b01);
    endtask

    task automatic run_vec(input int i);
        accept(vecs[i]);
        wait_out($sformatf("vec%0d", i), vecs[i].exp);
        handshake($sformatf("vec%0d", i));
    endtask

    initial begin
        logic [7:0] held;
        logic       stable, spurious;

        //          ss    x      wz     wr     wh     uz     ur     uh     bz     br     bh     exp
        vecs[0]  = '{1'b1, 8'h20, 8'h00, 8'h00, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h10};
        vecs[1]  = '{1'b0, 8'h20, 8'h00, 8'h00, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h18};
        vecs[2]  = '{1'b1, 8'h20, 8'h00, 8'h00, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h10};
        vecs[3]  = '{1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h7F, 8'h00, 8'h00, 8'h00, 8'h17};
        vecs[4]  = '{1'b1, 8'h20, 8'h00, 8'h00, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h10};
        vecs[5]  = '{1'b0, 8'h20, 8'h00, 8'h80, 8'h00, 8'h00, 8'h00, 8'h7F, 8'h00, 8'h00, 8'h00, 8'h08};
        vecs[6]  = '{1'b1, 8'h20, 8'h00, 8'h00, 8'hE0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hF0};
        vecs[7]  = '{1'b1, 8'h7F, 8'h00, 8'h00, 8'h7F, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h7F, 8'h10};
        vecs[8]  = '{1'b1, 8'h80, 8'h00, 8'h00, 8'h7F, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h80, 8'hF0};
        vecs[9]  = '{1'b1, 8'h20, 8'h7F, 8'h00, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h20};
        vecs[10] = '{1'b1, 8'h20, 8'h80, 8'h00, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        vecs[11] = '{1'b1, 8'h01, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF};

        #2;
        chk("reset_outputs", {y_valid, h_out}, 9'h000);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("x_ready_after_reset", x_ready, 1);

        for (int i = 0; i < 12; i++) run_vec(i);

        // Backpressure: output held for 5 cycles, new sample ignored.
        y_ready = 1'b0;
        accept(vecs[0]);
        wait_out("bp", 8'h10);
        held = h_out;
        stable = 1'b1;
        @(negedge clk);
        x_valid = 1'b1; seq_start = 1'b1; x_in = 8'h7F; Wh = 8'hE0;
        repeat (5) begin
            @(posedge clk);
            #1;
            if (!y_valid || h_out !== held || x_ready) stable = 1'b0;
        end
        chk("bp_stable", stable, 1);
        @(negedge clk);
        x_valid = 1'b0;
        handshake("bp");
        accept(vecs[1]);
        wait_out("bp_next", 8'h18);
        handshake("bp_next");

        // Reset while in CAND: step discarded, stored h cleared.
        accept(vecs[1]);
        @(posedge clk);
        #1;
        #1 rst = 1'b1;
        #1;
        chk("rst_cand_outputs", {y_valid, h_out, x_ready}, 10'h001);
        @(negedge clk);
        rst = 1'b0;
        spurious = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (y_valid) spurious = 1'b1;
        end
        chk("rst_cand_no_output", spurious, 0);
        accept(vecs[1]);
        wait_out("after_rst", 8'h10);
        handshake("after_rst");

        // Reset while holding output: y_valid drops without a clock edge.
        y_ready = 1'b0;
        accept(vecs[1]);
        wait_out("rst_out_pre", 8'h18);
        #2 rst = 1'b1;
        #1;
        chk("rst_out_async", {y_valid, h_out}, 9'h000);
        @(negedge clk);
        rst = 1'b0;
        y_ready = 1'b1;
        accept(vecs[1]);
        wait_out("after_rst2", 8'h10);
        handshake("after_rst2");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
